multicycle_control: RTL and testbench

//  Control unit for the multicycle RV32I core. It replaces the single-cycle decoder with a Moore FSM

---
 rtl/multicycle_control_if.sv | 28 ++
 rtl/multicycle_control.sv | 95 +++++++++
 tb/tb_multicycle_control.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields in, datapath control strobes out.
interface multicycle_control_if #(parameter int ALUCTRL_W = 3);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic [1:0]           result_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 reg_write;
    logic                 illegal;
    logic [3:0]           state_o;
    modport master (
        input  opcode, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, reg_write, illegal, state_o
    );
    modport slave (
        output opcode, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, reg_write, illegal, state_o
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing fetch/decode/execute/memory/writeback for a multicycle RV32I core.
module multicycle_control #(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_JAL    = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
    } ctl_t;
    function automatic ctl_t ctl_of(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1; end
            DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            EXECR:    begin c.alu_src_a = 2'b10; c.aluop = 2'b10; end
            EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.aluop = 2'b10; end
            ALUWB:    c.reg_write = 1'b1;
            BEQ:      begin c.alu_src_a = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
            JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction
    function automatic state_t next_of(state_t s, logic [6:0] op);
        case (s)
            FETCH:   return DECODE;
            DECODE:  return (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                            (op == 7'b0110011) ? EXECR :
                            (op == 7'b0010011) ? EXECI :
                            (op == 7'b1100011) ? BEQ :
                            (EN_JAL && op == 7'b1101111) ? JAL : FETCH;
            MEMADR:  return op[5] ? MEMWRITE : MEMREAD;
            MEMREAD: return MEMWB;
            EXECR, EXECI, JAL: return ALUWB;
            default: return FETCH;
        endcase
    endfunction
    state_t     state, nxt;
    ctl_t       ctl;
    logic [2:0] alu3;
    always_comb nxt = next_of(state, bus.opcode);
    // Output register is loaded with the decode of the state being entered, so it always matches state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ctl   <= ctl_of(FETCH);
        end else begin
            state <= nxt;
            ctl   <= ctl_of(nxt);
        end
    end
    always_comb begin
        alu3 = 3'd0;
        if (ctl.aluop == 2'b01)
            alu3 = 3'd1;
        else if (ctl.aluop == 2'b10)
            alu3 = (bus.funct3 == 3'b000) ? {2'b00, bus.opcode[5] & bus.funct7b5} :
                   (bus.funct3 == 3'b010) ? 3'd5 :
                   (bus.funct3 == 3'b100) ? 3'd4 :
                   (bus.funct3 == 3'b110) ? 3'd3 :
                   (bus.funct3 == 3'b111) ? 3'd2 : 3'd0;
    end
    // Everything is gated by rst_n so outputs drop the instant reset asserts, even mid-instruction.
    assign bus.pc_write    = rst_n & (ctl.pc_update | (ctl.branch & bus.zero));
    assign bus.adr_src     = rst_n & ctl.adr_src;
    assign bus.mem_write   = rst_n & ctl.mem_write;
    assign bus.ir_write    = rst_n & ctl.ir_write;
    assign bus.reg_write   = rst_n & ctl.reg_write;
    assign bus.result_src  = rst_n ? ctl.result_src : 2'b00;
    assign bus.alu_src_a   = rst_n ? ctl.alu_src_a : 2'b00;
    assign bus.alu_src_b   = rst_n ? ctl.alu_src_b : 2'b00;
    assign bus.alu_control = rst_n ? ALUCTRL_W'(alu3) : '0;
    assign bus.illegal     = rst_n & (state == DECODE) & (nxt == FETCH);
    assign bus.state_o     = rst_n ? state : 4'd0;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream vs. latency/strobe reference model, scoreboarded per cycle.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALUCTRL_W(3)) if1 ();
    multicycle_control_if #(.ALUCTRL_W(3)) if2 ();
    multicycle_control #(.ALUCTRL_W(3), .EN_JAL(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    multicycle_control #(.ALUCTRL_W(3), .EN_JAL(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
    assign if2.opcode   = 7'b1101111;
    assign if2.funct3   = 3'b000;
    assign if2.funct7b5 = 1'b0;
    assign if2.zero     = 1'b0;

    typedef struct {
        int st;
        bit pcw, irw, rw, mw, adr, ill;
        int rs, alu;
    } exp_t;
    exp_t q[$];
    int alu_tab[8] = '{0, 0, 5, 0, 4, 0, 3, 2};

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each instruction class walks a known state path; strobes follow from its role in that path.
    task automatic issue(logic [6:0] op, logic [2:0] f3, logic f7, logic z);
        int path[$];
        bit lw, sw, r, im, b, j;
        exp_t e;
        lw = op == 7'b0000011; sw = op == 7'b0100011; r = op == 7'b0110011;
        im = op == 7'b0010011; b  = op == 7'b1100011; j = op == 7'b1101111;
        path = lw ? '{0, 1, 2, 3, 4} : sw ? '{0, 1, 2, 5} : r ? '{0, 1, 6, 8} : im ? '{0, 1, 7, 8} :
               b ? '{0, 1, 9} : j ? '{0, 1, 10, 8} : '{0, 1};
        if1.opcode = op; if1.funct3 = f3; if1.funct7b5 = f7; if1.zero = z;
        for (int i = 0; i < path.size(); i++) begin
            bit last;
            last  = i == path.size() - 1;
            e.st  = path[i];
            e.pcw = (i == 0) || (j && i == 2) || (b && i == 2 && z);
            e.irw = i == 0;
            e.rw  = last && (lw || r || im || j);
            e.mw  = last && sw;
            e.adr = (lw || sw) && i == 3;
            e.ill = !(lw || sw || r || im || b || j) && i == 1;
            e.rs  = (i == 0) ? 2 : (lw && last) ? 1 : 0;
            e.alu = ((r || im) && i == 2) ? alu_tab[f3] + ((f3 == 3'b000 && r && f7) ? 1 : 0) :
                    (b && i == 2) ? 1 : 0;
            q.push_back(e);
        end
        repeat (path.size()) @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && q.size() > 0) begin
                e = q.pop_front();
                chk("state", 32'(if1.state_o), e.st);
                chk("pc_write", 32'(if1.pc_write), 32'(e.pcw));
                chk("ir_write", 32'(if1.ir_write), 32'(e.irw));
                chk("reg_write", 32'(if1.reg_write), 32'(e.rw));
                chk("mem_write", 32'(if1.mem_write), 32'(e.mw));
                chk("adr_src", 32'(if1.adr_src), 32'(e.adr));
                chk("illegal", 32'(if1.illegal), 32'(e.ill));
                chk("result_src", 32'(if1.result_src), e.rs);
                chk("alu_control", 32'(if1.alu_control), e.alu);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [6:0] op;
        bit found;
        if1.opcode = 7'b0; if1.funct3 = 3'b0; if1.funct7b5 = 1'b0; if1.zero = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ir_write", 32'(if1.ir_write), 0);
        chk("rst_pc_write", 32'(if1.pc_write), 0);
        chk("rst_alu_src_b", 32'(if1.alu_src_b), 0);
        chk("rst_state", 32'(if1.state_o), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        issue(7'b0000011, 3'b010, 1'b0, 1'b0);
        issue(7'b0100011, 3'b010, 1'b0, 1'b1);
        issue(7'b0110011, 3'b000, 1'b1, 1'b0);
        issue(7'b0010011, 3'b000, 1'b1, 1'b0);
        issue(7'b0010011, 3'b100, 1'b0, 1'b0);
        issue(7'b1100011, 3'b000, 1'b0, 1'b1);
        issue(7'b1100011, 3'b000, 1'b0, 1'b0);
        issue(7'b1101111, 3'b000, 1'b0, 1'b1);
        issue(7'b1111111, 3'b000, 1'b0, 1'b0);
        // Abandon a store in MEMWRITE with an asynchronous reset.
        mon_en = 1'b0;
        if1.opcode = 7'b0100011;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_state", 32'(if1.state_o), 5);
        chk("pre_rst_mem_write", 32'(if1.mem_write), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_write", 32'(if1.mem_write), 0);
        chk("rst_state_mid", 32'(if1.state_o), 0);
        chk("rst_reg_write", 32'(if1.reg_write), 0);
        chk("rst_adr_src", 32'(if1.adr_src), 0);
        chk("rst_result_src", 32'(if1.result_src), 0);
        chk("rst_alu_src_a", 32'(if1.alu_src_a), 0);
        chk("rst_ir_write_mid", 32'(if1.ir_write), 0);
        chk("rst_pc_write_mid", 32'(if1.pc_write), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("release_state", 32'(if1.state_o), 0);
        chk("release_ir_write", 32'(if1.ir_write), 1);
        mon_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                default: begin
                    op = 7'(($urandom));
                    while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})
                        op = 7'(($urandom));
                end
            endcase
            issue(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("scoreboard_empty", q.size(), 0);
        // Variant without JAL support must flag jal as illegal and fall back to FETCH.
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (if2.state_o == 4'd1) found = 1'b1;
        end
        chk("nojal_reach_decode", 32'(found), 1);
        chk("nojal_illegal", 32'(if2.illegal), 1);
        chk("nojal_reg_write", 32'(if2.reg_write), 0);
        @(negedge clk);
        chk("nojal_back_fetch", 32'(if2.state_o), 0);
        chk("nojal_illegal_drop", 32'(if2.illegal), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
